fp_vec_mul_ctrl: RTL

- Sequencer directly upstream of, and collecting results from, the double-precision multiplier stage. Used for element-wise products in the Kalman covariance/gain update.
- On start, streams up to 2^AW operand pairs from an operand buffer into the multiplier at one pair per cycle.
- Captures each product, in order, into a result buffer. Pulses done when all products are written or when the result watchdog expires.

---
 rtl/fp_vec_mul_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fp_vec_mul_ctrl.sv
// fp_vec_mul_ctrl
// Sequencer in front of the double-precision multiplier. A launch streams up
// to 2^AW operand pairs out of the operand buffer, one pair per cycle, into the
// multiplier. Products are written back in arrival order into the result
// buffer. A watchdog aborts the run with err if the multiplier stops
// returning products while the block waits for them.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, len               launch request and vector length (clamped to 2^AW)
//   busy, done, err          status: running, one-cycle completion, watchdog abort
//   op_rd_en, op_rd_addr     operand buffer read port (data one cycle later)
//   op_a_data, op_b_data     operand buffer read data
//   mul_a, mul_b, mul_valid  registered operands to the multiplier
//   mul_finish, mul_result   product return from the multiplier
//   res_wr_en/addr/data      registered result buffer write port
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; all strobes low
// S_ISSUE  | one operand read per cycle until N reads have been made
// S_DRAIN  | reads finished; collecting remaining products, watchdog running
// S_DONE   | one-cycle done pulse, then back to idle
module fp_vec_mul_ctrl #(
  parameter int DW      = 64,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64   // must be at least 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          op_rd_en,
  output logic [AW-1:0] op_rd_addr,
  input  logic [DW-1:0] op_a_data,
  input  logic [DW-1:0] op_b_data,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  output logic          mul_valid,
  input  logic          mul_finish,
  input  logic [DW-1:0] mul_result,
  output logic          res_wr_en,
  output logic [AW-1:0] res_wr_addr,
  output logic [DW-1:0] res_wr_data
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]    MAX_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]    CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]  PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   n_len_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   issue_cnt_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   cmpl_cnt_q;
  logic [WDW-1:0] wd_cnt_q;
  logic          err_q;
  logic          rd_vld_q;

  logic [AW:0]   eff_len;
  logic          start_ok;
  logic          accept;
  logic          all_done;
  logic          wd_expire;

  assign eff_len  = (len > MAX_LEN) ? MAX_LEN : len;
  assign start_ok = (state_q == S_IDLE) && start;
  // Products beyond the N-th are dropped rather than overrunning the buffer.
  assign accept   = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                    mul_finish && (cmpl_cnt_q < n_len_q);
  assign all_done = (cmpl_cnt_q == n_len_q);
  // A product arriving on the terminal cycle counts as progress.
  assign wd_expire = (state_q == S_DRAIN) && !mul_finish && !all_done &&
                     (wd_cnt_q <= WD_ONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    op_rd_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (eff_len == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        busy     = 1'b1;
        op_rd_en = 1'b1;
        if (issue_cnt_q + CNT_ONE == n_len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (all_done || wd_expire) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign op_rd_addr = rd_ptr_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_len_q     <= '0;
      rd_ptr_q    <= '0;
      issue_cnt_q <= '0;
      wr_ptr_q    <= '0;
      cmpl_cnt_q  <= '0;
      wd_cnt_q    <= '0;
      err_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
      mul_valid   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
    end else begin
      if (start_ok) begin
        n_len_q     <= eff_len;
        rd_ptr_q    <= '0;
        issue_cnt_q <= '0;
        wr_ptr_q    <= '0;
        cmpl_cnt_q  <= '0;
        err_q       <= 1'b0;
      end

      // Watchdog is a down-counter: held at full load while issuing, reloaded
      // by every product in drain, and expires on its terminal count.
      if (state_q == S_ISSUE) begin
        rd_ptr_q    <= rd_ptr_q + PTR_ONE;
        issue_cnt_q <= issue_cnt_q + CNT_ONE;
        wd_cnt_q    <= WD_LOAD;
      end else if (state_q == S_DRAIN) begin
        if (mul_finish)            wd_cnt_q <= WD_LOAD;
        else if (wd_cnt_q != '0)   wd_cnt_q <= wd_cnt_q - WD_ONE;
      end

      if (wd_expire) err_q <= 1'b1;

      // Read data lands one cycle after the strobe; register it once more so
      // the multiplier sees clean flop outputs.
      rd_vld_q  <= op_rd_en;
      mul_valid <= rd_vld_q;
      if (rd_vld_q) begin
        mul_a <= op_a_data;
        mul_b <= op_b_data;
      end

      res_wr_en <= accept;
      if (accept) begin
        res_wr_addr <= wr_ptr_q;
        res_wr_data <= mul_result;
        wr_ptr_q    <= wr_ptr_q + PTR_ONE;
        cmpl_cnt_q  <= cmpl_cnt_q + CNT_ONE;
      end
    end
  end

endmodule
